quad_encoder_periph: RTL and testbench

//  Quadrature encoder peripheral on the PicoSoC iomem bus; one instance per wheel (left/right).

---
 rtl/quad_enc_pkg.sv | 56 +++++
 rtl/quad_decoder.sv | 83 ++++++++
 rtl/quad_encoder_periph.sv | 155 +++++++++++++++
 tb/tb_quad_encoder_periph.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/quad_enc_pkg.sv
// Shared definitions for the quadrature encoder peripheral: register map,
// bit positions, step encoding and the Gray-sequence helpers.
package quad_enc_pkg;

    localparam logic [7:0] OFF_COUNT  = 8'h00;
    localparam logic [7:0] OFF_CTRL   = 8'h04;
    localparam logic [7:0] OFF_VEL    = 8'h08;
    localparam logic [7:0] OFF_STATUS = 8'h0C;

    localparam int CTRL_EN    = 0;
    localparam int CTRL_INV   = 1;
    localparam int CTRL_CLR   = 2;
    localparam int STATUS_ERR = 0;
    localparam int STATUS_A   = 1;
    localparam int STATUS_B   = 2;

    typedef enum logic [1:0] {
        STEP_NONE = 2'b00,
        STEP_FWD  = 2'b01,
        STEP_REV  = 2'b11
    } step_t;

    typedef enum logic [1:0] {
        AB_00 = 2'b00,
        AB_01 = 2'b01,
        AB_11 = 2'b11,
        AB_10 = 2'b10
    } ab_state_t;

    typedef enum logic {
        BUS_IDLE,
        BUS_ACK
    } bus_state_t;

    // Forward successor in the x4 Gray cycle 00 -> 01 -> 11 -> 10 -> 00.
    function automatic logic [1:0] gray_next(input logic [1:0] ab);
        case (ab)
            2'b00:   return 2'b01;
            2'b01:   return 2'b11;
            2'b11:   return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_value,
                                                input logic [31:0] wdata,
                                                input logic [3:0]  strb);
        logic [31:0] result;
        result = old_value;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) result[8*i +: 8] = wdata[8*i +: 8];
        end
        return result;
    endfunction

endpackage

// File: rtl/quad_decoder.sv
// Pin synchroniser, stability filter and x4 quadrature decode FSM.
// Emits one-cycle step_up/step_dn/err_pulse strobes and the live synchronised AB.
module quad_decoder
    import quad_enc_pkg::*;
#(
    parameter int FILTER_LEN = 4
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       enc_a,
    input  logic       enc_b,
    output logic       step_up,
    output logic       step_dn,
    output logic       err_pulse,
    output logic [1:0] ab
);

    localparam logic [3:0] FLEN = 4'(FILTER_LEN);

    logic [1:0] sync1, sync2, cand, cand_next, filt;
    logic [3:0] stable_cnt, stable_next;
    ab_state_t  state, state_next;
    logic       up_d, dn_d, err_d;

    // A candidate value is accepted only once it has been seen FILTER_LEN times in a row.
    always_comb begin
        cand_next   = cand;
        stable_next = stable_cnt;
        if (sync2 != cand) begin
            cand_next   = sync2;
            stable_next = 4'd1;
        end else if (stable_cnt < FLEN) begin
            stable_next = stable_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1      <= 2'b00;
            sync2      <= 2'b00;
            cand       <= 2'b00;
            stable_cnt <= 4'd0;
            filt       <= 2'b00;
        end else begin
            sync1      <= {enc_a, enc_b};
            sync2      <= sync1;
            cand       <= cand_next;
            stable_cnt <= stable_next;
            if (stable_next >= FLEN) filt <= cand_next;
        end
    end

    always_comb begin
        state_next = ab_state_t'(filt);
        up_d       = 1'b0;
        dn_d       = 1'b0;
        err_d      = 1'b0;
        if (filt == gray_next(state)) begin
            up_d = 1'b1;
        end else if (state == gray_next(filt)) begin
            dn_d = 1'b1;
        end else if (filt != state) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= AB_00;
            step_up   <= 1'b0;
            step_dn   <= 1'b0;
            err_pulse <= 1'b0;
        end else begin
            state     <= state_next;
            step_up   <= up_d;
            step_dn   <= dn_d;
            err_pulse <= err_d;
        end
    end

    assign ab = sync2;

endmodule

// File: rtl/quad_encoder_periph.sv
// Quadrature encoder peripheral on the PicoSoC iomem bus: register file,
// one-cycle bus acknowledge, wrapping position counter and velocity window.
module quad_encoder_periph
    import quad_enc_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR     = 32'h0300_0300,
    parameter int          FILTER_LEN    = 4,
    parameter int          WINDOW_CYCLES = 16000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        enc_a,
    input  logic        enc_b,
    input  logic        iomem_valid,
    input  logic [3:0]  iomem_wstrb,
    input  logic [31:0] iomem_addr,
    input  logic [31:0] iomem_wdata,
    output logic        iomem_ready,
    output logic [31:0] iomem_rdata,
    output logic [31:0] count_out
);

    localparam int WIN_W = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
    localparam logic [WIN_W-1:0]  WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);
    localparam logic signed [15:0] ACC_MAX = 16'sd32767;
    localparam logic signed [15:0] ACC_MIN = -16'sd32767;

    logic        step_up, step_dn, err_pulse;
    logic [1:0]  ab;
    bus_state_t  bus_state, bus_next;
    logic        sel, wr, wr_byte0;
    logic [7:0]  offset;
    logic [31:0] rd_data;
    logic        en, inv, err, clr;
    logic [31:0] count;
    step_t       step;
    logic [WIN_W-1:0]    win_cnt;
    logic signed [15:0]  accum, accum_next;
    logic signed [31:0]  velocity;

    quad_decoder #(.FILTER_LEN(FILTER_LEN)) u_decoder (
        .clk       (clk),
        .resetn    (resetn),
        .enc_a     (enc_a),
        .enc_b     (enc_b),
        .step_up   (step_up),
        .step_dn   (step_dn),
        .err_pulse (err_pulse),
        .ab        (ab)
    );

    assign offset   = iomem_addr[7:0];
    assign sel      = iomem_valid && !iomem_ready && (iomem_addr[31:8] == BASE_ADDR[31:8]);
    assign wr       = sel && (iomem_wstrb != 4'b0000);
    assign wr_byte0 = wr && iomem_wstrb[0];
    assign clr      = wr_byte0 && (offset == OFF_CTRL) && iomem_wdata[CTRL_CLR];

    // Ready is the ACK state itself, so it always falls back for at least one cycle.
    always_comb begin
        bus_next = bus_state;
        case (bus_state)
            BUS_IDLE: if (sel) bus_next = BUS_ACK;
            BUS_ACK:  bus_next = BUS_IDLE;
            default:  bus_next = BUS_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) bus_state <= BUS_IDLE;
        else         bus_state <= bus_next;
    end

    assign iomem_ready = (bus_state == BUS_ACK);

    always_comb begin
        rd_data = '0;
        case (offset)
            OFF_COUNT:  rd_data = count;
            OFF_CTRL: begin
                rd_data[CTRL_EN]  = en;
                rd_data[CTRL_INV] = inv;
            end
            OFF_VEL:    rd_data = velocity;
            OFF_STATUS: begin
                rd_data[STATUS_ERR] = err;
                rd_data[STATUS_A]   = ab[1];
                rd_data[STATUS_B]   = ab[0];
            end
            default:    rd_data = '0;
        endcase
    end

    always_comb begin
        step = STEP_NONE;
        if (en && step_up)      step = inv ? STEP_REV : STEP_FWD;
        else if (en && step_dn) step = inv ? STEP_FWD : STEP_REV;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            iomem_rdata <= '0;
            en          <= 1'b0;
            inv         <= 1'b0;
            err         <= 1'b0;
            count       <= '0;
        end else begin
            iomem_rdata <= (sel && !wr) ? rd_data : 32'h0;
            if (wr_byte0 && offset == OFF_CTRL) begin
                en  <= iomem_wdata[CTRL_EN];
                inv <= iomem_wdata[CTRL_INV];
            end
            if (err_pulse)
                err <= 1'b1;
            else if (wr_byte0 && offset == OFF_STATUS && iomem_wdata[STATUS_ERR])
                err <= 1'b0;
            // Clear beats a software write, which beats a decoder step that same cycle.
            if (clr)
                count <= '0;
            else if (wr && offset == OFF_COUNT)
                count <= merge_bytes(count, iomem_wdata, iomem_wstrb);
            else if (step == STEP_FWD)
                count <= count + 32'd1;
            else if (step == STEP_REV)
                count <= count - 32'd1;
        end
    end

    always_comb begin
        accum_next = accum;
        case (step)
            STEP_FWD: if (accum != ACC_MAX) accum_next = accum + 16'sd1;
            STEP_REV: if (accum != ACC_MIN) accum_next = accum - 16'sd1;
            default:  accum_next = accum;
        endcase
    end

    // The terminal cycle's own step still lands in the window being published.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            win_cnt  <= '0;
            accum    <= '0;
            velocity <= '0;
        end else if (win_cnt == WIN_LAST) begin
            win_cnt  <= '0;
            accum    <= '0;
            velocity <= {{16{accum_next[15]}}, accum_next};
        end else begin
            win_cnt  <= win_cnt + WIN_W'(1);
            accum    <= accum_next;
        end
    end

    assign count_out = count;

endmodule

// File: tb/tb_quad_encoder_periph.sv
// Self-checking bench: randomized encoder motion and bus traffic compared
// against a plain arithmetic model of position, control and status.
module tb_quad_encoder_periph;

    localparam logic [31:0] BASE       = 32'h0300_0300;
    localparam int          FILTER_LEN = 4;
    localparam int          WINDOW     = 16000;

    logic        clk, resetn, enc_a, enc_b;
    logic        iomem_valid, iomem_ready;
    logic [3:0]  iomem_wstrb;
    logic [31:0] iomem_addr, iomem_wdata, iomem_rdata, count_out;

    int          vectors, miscompares;
    logic [31:0] model_count;
    bit          model_en, model_inv;
    int          gray_idx;
    logic [1:0]  gray_seq [4];

    quad_encoder_periph #(
        .BASE_ADDR     (BASE),
        .FILTER_LEN    (FILTER_LEN),
        .WINDOW_CYCLES (WINDOW)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .enc_a       (enc_a),
        .enc_b       (enc_b),
        .iomem_valid (iomem_valid),
        .iomem_wstrb (iomem_wstrb),
        .iomem_addr  (iomem_addr),
        .iomem_wdata (iomem_wdata),
        .iomem_ready (iomem_ready),
        .iomem_rdata (iomem_rdata),
        .count_out   (count_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Move the encoder one Gray position (dir>0 forward) and wait gap cycles.
    task automatic applyStimulus(input int dir, input int gap);
        @(negedge clk);
        gray_idx = (dir > 0) ? (gray_idx + 1) % 4 : (gray_idx + 3) % 4;
        {enc_a, enc_b} = gray_seq[gray_idx];
        if (model_en) begin
            if ((dir > 0) != model_inv) model_count = model_count + 32'd1;
            else                        model_count = model_count - 32'd1;
        end
        repeat (gap) @(posedge clk);
    endtask

    task automatic bus_xfer(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, output logic [31:0] rdata, output bit acked);
        @(negedge clk);
        iomem_valid = 1'b1;
        iomem_addr  = addr;
        iomem_wdata = data;
        iomem_wstrb = strb;
        acked = 1'b0;
        rdata = '0;
        for (int i = 0; i < 8 && !acked; i++) begin
            @(posedge clk);
            #1;
            if (iomem_ready) begin
                acked = 1'b1;
                rdata = iomem_rdata;
            end
        end
        iomem_valid = 1'b0;
        iomem_wstrb = 4'b0000;
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        logic [31:0] unused_rd;
        bit          acked;
        bus_xfer(addr, data, strb, unused_rd, acked);
        checkOutput("write_ack", {31'b0, acked}, 32'd1);
    endtask

    task automatic read_check(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] rd;
        bit          acked;
        bus_xfer(addr, 32'h0, 4'b0000, rd, acked);
        checkOutput({tag, "_ack"}, {31'b0, acked}, 32'd1);
        checkOutput(tag, rd, exp);
        @(posedge clk);
        #1;
        checkOutput({tag, "_ready_drop"}, {31'b0, iomem_ready}, 32'd0);
    endtask

    function automatic logic [31:0] status_exp(input bit e);
        return {29'b0, enc_b, enc_a, e};
    endfunction

    function automatic logic [31:0] byte_merge(input logic [31:0] old_value, input logic [31:0] v,
                                               input logic [3:0] strb);
        logic [31:0] r;
        r = old_value;
        if (strb[0]) r[7:0]   = v[7:0];
        if (strb[1]) r[15:8]  = v[15:8];
        if (strb[2]) r[23:16] = v[23:16];
        if (strb[3]) r[31:24] = v[31:24];
        return r;
    endfunction

    initial begin
        int          lat;
        bit          found, seen;
        logic [31:0] prev, val, c;
        logic [3:0]  strb;

        gray_seq[0] = 2'b00; gray_seq[1] = 2'b01; gray_seq[2] = 2'b11; gray_seq[3] = 2'b10;
        vectors = 0; miscompares = 0;
        gray_idx = 0; model_count = 0; model_en = 0; model_inv = 0;
        resetn = 1'b0; enc_a = 1'b0; enc_b = 1'b0;
        iomem_valid = 1'b0; iomem_wstrb = 4'b0; iomem_addr = '0; iomem_wdata = '0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_ready", {31'b0, iomem_ready}, 32'd0);
        checkOutput("rst_rdata", iomem_rdata, 32'd0);
        @(negedge clk);
        resetn = 1'b1;

        read_check("rst_count",  BASE + 32'h00, 32'h0);
        read_check("rst_ctrl",   BASE + 32'h04, 32'h0);
        read_check("rst_vel",    BASE + 32'h08, 32'h0);
        read_check("rst_status", BASE + 32'h0C, status_exp(1'b0));

        // Disabled counter still lets the decoder track the pins.
        applyStimulus(1, 12);
        read_check("live_pins",   BASE + 32'h0C, status_exp(1'b0));
        read_check("count_en0",   BASE + 32'h00, model_count);

        bus_write(BASE + 32'h04, 32'h1, 4'hF);
        model_en = 1;
        for (int i = 0; i < 400; i++) applyStimulus(1, 8);
        repeat (10) @(posedge clk);
        read_check("count_400", BASE + 32'h00, 32'd400);

        bus_write(BASE + 32'h04, 32'h3, 4'hF);
        model_inv = 1;
        for (int i = 0; i < 8; i++) applyStimulus(1, 8);
        repeat (10) @(posedge clk);
        read_check("count_inv", BASE + 32'h00, 32'd392);
        read_check("ctrl_rd",   BASE + 32'h04, 32'h3);

        bus_write(BASE + 32'h04, 32'h7, 4'hF);
        model_count = 0;
        read_check("count_clr", BASE + 32'h00, 32'h0);
        read_check("ctrl_clr0", BASE + 32'h04, 32'h3);
        bus_write(BASE + 32'h04, 32'h1, 4'hF);
        model_inv = 0;

        bus_write(BASE + 32'h10, 32'hFFFF_FFFF, 4'hF);
        read_check("unmapped", BASE + 32'h10, 32'h0);
        read_check("count_unmapped_wr", BASE + 32'h00, model_count);

        @(negedge clk);
        iomem_valid = 1'b1;
        iomem_addr  = BASE + 32'h100;
        iomem_wstrb = 4'b0000;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (iomem_ready) seen = 1'b1;
        end
        iomem_valid = 1'b0;
        checkOutput("other_page", {31'b0, seen}, 32'd0);

        for (int it = 0; it < 12; it++) begin
            val  = $urandom;
            strb = 4'($urandom_range(1, 15));
            bus_write(BASE + 32'h00, val, strb);
            model_count = byte_merge(model_count, val, strb);
            read_check("rand_count_wr", BASE + 32'h00, model_count);
            c = 32'($urandom_range(0, 3));
            bus_write(BASE + 32'h04, c, 4'h1);
            model_en  = c[0];
            model_inv = c[1];
            for (int k = 0, n = $urandom_range(5, 25); k < n; k++)
                applyStimulus(($urandom_range(0, 1) == 1) ? 1 : -1, $urandom_range(6, 15));
            repeat (12) @(posedge clk);
            read_check("rand_count", BASE + 32'h00, model_count);
        end

        bus_write(BASE + 32'h04, 32'h1, 4'hF);
        model_en = 1; model_inv = 0;

        bus_write(BASE + 32'h00, 32'h7FFF_FFFF, 4'hF);
        model_count = 32'h7FFF_FFFF;
        applyStimulus(1, 12);
        read_check("wrap_pos", BASE + 32'h00, 32'h8000_0000);
        bus_write(BASE + 32'h00, 32'h0, 4'hF);
        model_count = 32'h0;
        applyStimulus(-1, 12);
        read_check("wrap_neg", BASE + 32'h00, 32'hFFFF_FFFF);

        // Glitch one cycle shorter than the filter must be ignored.
        @(negedge clk);
        enc_a = ~enc_a;
        repeat (FILTER_LEN - 1) @(negedge clk);
        enc_a = ~enc_a;
        repeat (12) @(posedge clk);
        read_check("glitch_count",  BASE + 32'h00, model_count);
        read_check("glitch_status", BASE + 32'h0C, status_exp(1'b0));

        @(negedge clk);
        gray_idx = (gray_idx + 2) % 4;
        {enc_a, enc_b} = gray_seq[gray_idx];
        repeat (12) @(posedge clk);
        read_check("jump_err",   BASE + 32'h0C, status_exp(1'b1));
        read_check("jump_count", BASE + 32'h00, model_count);
        bus_write(BASE + 32'h0C, 32'h1, 4'h1);
        read_check("err_w1c",    BASE + 32'h0C, status_exp(1'b0));
        applyStimulus(1, 12);
        read_check("resync_step", BASE + 32'h00, model_count);

        for (int i = 0; i < 330; i++) applyStimulus(1, (i == 329) ? 20 : 100);
        read_check("vel_fwd", BASE + 32'h08, 32'd160);
        for (int i = 0; i < 330; i++) applyStimulus(-1, (i == 329) ? 20 : 100);
        read_check("vel_rev", BASE + 32'h08, 32'hFFFF_FF60);
        repeat (10) @(posedge clk);
        read_check("vel_count", BASE + 32'h00, model_count);

        // Measure when a step reaches the counter, then land a COUNT write on that cycle.
        applyStimulus(1, 0);
        prev  = count_out;
        found = 1'b0;
        lat   = 0;
        for (int i = 1; i <= 20 && !found; i++) begin
            @(posedge clk);
            #1;
            if (count_out != prev) begin
                found = 1'b1;
                lat   = i;
            end
        end
        checkOutput("step_seen", {31'b0, found}, 32'd1);
        if (lat < 2) lat = 2;
        repeat (12) @(posedge clk);
        applyStimulus(1, 0);
        repeat (lat - 2) @(negedge clk);
        bus_write(BASE + 32'h00, 32'h1234_5678, 4'hF);
        model_count = 32'h1234_5678;
        repeat (12) @(posedge clk);
        read_check("wr_vs_step", BASE + 32'h00, 32'h1234_5678);

        @(negedge clk);
        iomem_valid = 1'b1;
        iomem_addr  = BASE + 32'h00;
        iomem_wstrb = 4'b0000;
        @(posedge clk);
        #1;
        checkOutput("mid_ready", {31'b0, iomem_ready}, 32'd1);
        #2;
        resetn = 1'b0;
        enc_a  = 1'b0;
        enc_b  = 1'b0;
        #1;
        checkOutput("rst_async_ready", {31'b0, iomem_ready}, 32'd0);
        @(posedge clk);
        #1;
        checkOutput("rst_edge_ready", {31'b0, iomem_ready}, 32'd0);
        checkOutput("rst_edge_count", count_out, 32'd0);
        @(negedge clk);
        iomem_valid = 1'b0;
        resetn = 1'b1;
        gray_idx = 0; model_count = 0; model_en = 0; model_inv = 0;
        read_check("post_rst_ctrl",   BASE + 32'h04, 32'h0);
        read_check("post_rst_status", BASE + 32'h0C, status_exp(1'b0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
